// File: rtl/gpio_word_packer_if.sv
// Byte-in / word-out stream bundle between the GPIO pins, the packer and the crossbar lane.
// The master side is the upstream source and downstream sink; the slave side is the packer.
interface gpio_word_packer_if #(
  parameter int BYTE_W  = 8,
  parameter int N_BYTES = 4
) ();
  localparam int WORD_W = BYTE_W * N_BYTES;
  localparam int LEN_W  = $clog2(N_BYTES + 1);

  logic              i_stream_val;
  logic [BYTE_W-1:0] i_stream_data;
  logic              i_stream_rdy;
  logic              flush;
  logic              o_stream_val;
  logic [WORD_W-1:0] o_stream_data;
  logic [LEN_W-1:0]  o_stream_len;
  logic              o_stream_rdy;
  logic              busy;

  modport master (
    output i_stream_val, i_stream_data, flush, o_stream_rdy,
    input  i_stream_rdy, o_stream_val, o_stream_data, o_stream_len, busy
  );

  modport slave (
    input  i_stream_val, i_stream_data, flush, o_stream_rdy,
    output i_stream_rdy, o_stream_val, o_stream_data, o_stream_len, busy
  );
endinterface

// File: rtl/gpio_word_packer.sv
// Packs a little-endian byte stream into N_BYTES-wide words with an assembly and an output
// register; partial words leave zero-padded on an explicit flush or after an idle timeout.
module gpio_word_packer #(
  parameter int BYTE_W  = 8,
  parameter int N_BYTES = 4,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  gpio_word_packer_if.slave bus
);
  localparam int WORD_W = BYTE_W * N_BYTES;
  localparam int CNT_W  = $clog2(N_BYTES + 1);
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(N_BYTES);
  localparam logic [IDLE_W-1:0] IDLE_MAX = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0]  asm_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [WORD_W-1:0] asm_data;
  logic [WORD_W-1:0] asm_merged;
  logic [WORD_W-1:0] out_data;
  logic [CNT_W-1:0]  out_len;
  logic [IDLE_W-1:0] idle_cnt;
  logic              out_full;
  logic              flush_pend;
  logic              rdy_en;

  logic in_fire;
  logic out_fire;
  logic out_free;
  logic timeout_hit;
  logic flush_req;
  logic xfer;

  // rdy_en keeps the input closed during reset and opens it on the first edge after release.
  assign bus.i_stream_rdy = rdy_en && (asm_cnt != FULL_CNT);

  assign in_fire     = bus.i_stream_val && bus.i_stream_rdy;
  assign out_fire    = out_full && bus.o_stream_rdy;
  assign out_free    = !out_full || out_fire;
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == IDLE_MAX) && !in_fire;
  assign flush_req   = (bus.flush || timeout_hit) && (asm_cnt != '0);
  assign cnt_next    = asm_cnt + CNT_W'(in_fire);

  // A word leaves when it is complete or flushed, and only into a free (or freeing) output slot.
  assign xfer = out_free && ((cnt_next == FULL_CNT) || flush_req || flush_pend);

  // The byte arriving this cycle is merged in before the transfer so it is never lost.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    asm_merged = asm_data;
    if (in_fire) asm_merged[int'(asm_cnt) * BYTE_W +: BYTE_W] = bus.i_stream_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_cnt    <= '0;
      asm_data   <= '0;
      out_data   <= '0;
      out_len    <= '0;
      out_full   <= 1'b0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;

      if (xfer) begin
        asm_cnt    <= '0;
        asm_data   <= '0;
        out_data   <= asm_merged;
        out_len    <= cnt_next;
        out_full   <= 1'b1;
        flush_pend <= 1'b0;
      end else begin
        asm_cnt  <= cnt_next;
        asm_data <= asm_merged;
        if (out_fire)  out_full   <= 1'b0;
        if (flush_req) flush_pend <= 1'b1;
      end

      if (xfer || in_fire || (asm_cnt == '0)) idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)          idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign bus.o_stream_val  = out_full;
  assign bus.o_stream_data = out_data;
  assign bus.o_stream_len  = out_len;
  assign bus.busy          = (asm_cnt != '0) || out_full;
endmodule

// File: tb/tb_gpio_word_packer.sv
// Self-checking bench for gpio_word_packer: vector tables, corner-case sequences and a
// randomized run compared against a queue-based model of the packing rules.
module tb_gpio_word_packer;
  localparam int TMO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gpio_word_packer_if #(.BYTE_W(8), .N_BYTES(4)) bus ();
  gpio_word_packer_if #(.BYTE_W(8), .N_BYTES(4)) bus0 ();

  gpio_word_packer #(.BYTE_W(8), .N_BYTES(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  gpio_word_packer #(.BYTE_W(8), .N_BYTES(4), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (main instance, TIMEOUT=16) ----------------
  logic [7:0]  asm_q[$];
  logic [31:0] m_out_data;
  int          m_out_len;
  bit          m_out_full;
  int          m_idle;
  bit          m_pend;
  bit          m_rdy_en;

  function automatic bit model_rdy();
    return m_rdy_en && (asm_q.size() < 4);
  endfunction

  task automatic model_reset();
    asm_q.delete();
    m_out_data = '0;
    m_out_len  = 0;
    m_out_full = 0;
    m_idle     = 0;
    m_pend     = 0;
    m_rdy_en   = 0;
  endtask

  task automatic model_step();
    bit fire, ofire, tmo, freq, want, slot_free;
    int pre;
    if (!reset) return;
    fire  = bus.i_stream_val && model_rdy();
    ofire = m_out_full && bus.o_stream_rdy;
    pre   = asm_q.size();
    tmo   = (TMO != 0) && (m_idle == TMO - 1) && !fire;
    freq  = (bus.flush || tmo) && (pre > 0);
    if (fire) asm_q.push_back(bus.i_stream_data);
    want      = (asm_q.size() == 4) || freq || m_pend;
    slot_free = !m_out_full || ofire;
    if (ofire) m_out_full = 0;
    if (want && slot_free) begin
      m_out_data = '0;
      foreach (asm_q[i]) m_out_data = m_out_data | (32'(asm_q[i]) << (8 * i));
      m_out_len  = asm_q.size();
      m_out_full = 1;
      asm_q.delete();
      m_pend = 0;
      m_idle = 0;
    end else begin
      if (freq) m_pend = 1;
      if (fire || pre == 0)     m_idle = 0;
      else if (m_idle < TMO - 1) m_idle++;
    end
    m_rdy_en = 1;
  endtask

  task automatic check_model(string tag);
    check({tag, ".val"},  32'(bus.o_stream_val), 32'(m_out_full));
    check({tag, ".rdy"},  32'(bus.i_stream_rdy), 32'(model_rdy()));
    check({tag, ".busy"}, 32'(bus.busy), 32'((asm_q.size() != 0) || m_out_full));
    if (m_out_full) begin
      check({tag, ".data"}, bus.o_stream_data, m_out_data);
      check({tag, ".len"},  32'(bus.o_stream_len), 32'(m_out_len));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(bit v, logic [7:0] d, bit f, bit r);
    bus.i_stream_val  = v;
    bus.i_stream_data = d;
    bus.flush         = f;
    bus.o_stream_rdy  = r;
  endtask

  // Inputs change after the negedge; the model advances with the posedge; outputs are sampled on the negedge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    bit          val;
    logic [7:0]  data;
    bit          flush;
    bit          ordy;
    bit          e_val;
    logic [31:0] e_data;
    logic [2:0]  e_len;
    bit          e_rdy;
    bit          e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, logic [7:0] d, bit f, bit r,
                              bit ev, logic [31:0] ed, logic [2:0] el, bit er, bit eb);
    vec_t x;
    x.val = v; x.data = d; x.flush = f; x.ordy = r;
    x.e_val = ev; x.e_data = ed; x.e_len = el; x.e_rdy = er; x.e_busy = eb;
    return x;
  endfunction

  int          first_k;
  logic [31:0] cap_data;
  logic [2:0]  cap_len;
  int          spurious;

  initial begin
    // basic pack, back-to-back with the crossbar always ready
    vecs.push_back(mk(1, 8'h11, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 8'h22, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 8'h33, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 8'h44, 0, 1, 1, 32'h44332211, 4, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 1, 0));
    // backpressure: second word fills behind the held one, then input stalls
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 8'h02, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 8'h03, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 8'h04, 0, 0, 1, 32'h04030201, 4, 1, 1));
    vecs.push_back(mk(1, 8'h05, 0, 0, 1, 32'h04030201, 4, 1, 1));
    vecs.push_back(mk(1, 8'h06, 0, 0, 1, 32'h04030201, 4, 1, 1));
    vecs.push_back(mk(1, 8'h07, 0, 0, 1, 32'h04030201, 4, 1, 1));
    vecs.push_back(mk(1, 8'h08, 0, 0, 1, 32'h04030201, 4, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 32'h04030201, 4, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 32'h08070605, 4, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 1, 0));
    // explicit flush of a 2-byte partial, then a flush on an empty packer
    vecs.push_back(mk(1, 8'hAA, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 8'hBB, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 32'h0000BBAA, 2, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 1, 0));

    model_reset();
    drive(0, 8'h00, 0, 0);
    bus0.i_stream_val = 0; bus0.i_stream_data = '0; bus0.flush = 0; bus0.o_stream_rdy = 0;

    // reset state
    #12;
    check("rst.val",  32'(bus.o_stream_val), 0);
    check("rst.data", bus.o_stream_data, 0);
    check("rst.len",  32'(bus.o_stream_len), 0);
    check("rst.rdy",  32'(bus.i_stream_rdy), 0);
    check("rst.busy", 32'(bus.busy), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    step();
    check("post_rst.rdy", 32'(bus.i_stream_rdy), 1);

    // table-driven vectors
    foreach (vecs[i]) begin
      drive(vecs[i].val, vecs[i].data, vecs[i].flush, vecs[i].ordy);
      step();
      check($sformatf("v%0d.val", i),  32'(bus.o_stream_val), 32'(vecs[i].e_val));
      check($sformatf("v%0d.rdy", i),  32'(bus.i_stream_rdy), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d.busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_val) begin
        check($sformatf("v%0d.data", i), bus.o_stream_data, vecs[i].e_data);
        check($sformatf("v%0d.len", i),  32'(bus.o_stream_len), 32'(vecs[i].e_len));
      end
    end

    // timeout: single byte, then idle until the auto-flush
    drive(1, 8'h5A, 0, 1);
    step();
    drive(0, 8'h00, 0, 1);
    first_k = -1;
    cap_data = '0;
    cap_len  = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.o_stream_val && first_k < 0) begin
        first_k  = k;
        cap_data = bus.o_stream_data;
        cap_len  = bus.o_stream_len;
      end
    end
    check("tmo.cycles", 32'(first_k), 32'd16);
    check("tmo.data", cap_data, 32'h0000005A);
    check("tmo.len",  32'(cap_len), 1);

    // timeout disabled: a lone byte stays put for 100 idle cycles
    bus0.i_stream_val = 1; bus0.i_stream_data = 8'h5A; bus0.o_stream_rdy = 1;
    step();
    bus0.i_stream_val = 0;
    spurious = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus0.o_stream_val) spurious++;
    end
    check("tmo0.no_output", 32'(spurious), 0);
    check("tmo0.busy", 32'(bus0.busy), 1);
    bus0.flush = 1;
    step();
    bus0.flush = 0;
    check("tmo0.flush_val",  32'(bus0.o_stream_val), 1);
    check("tmo0.flush_data", bus0.o_stream_data, 32'h0000005A);
    step();

    // pending flush behind a held word
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hA1 + 8'(i), 0, 0);
      step();
    end
    drive(1, 8'hC3, 0, 0);
    step();
    drive(0, 8'h00, 1, 0);
    step();
    drive(0, 8'h00, 0, 0);
    step();
    step();
    check("pend.hold_val",  32'(bus.o_stream_val), 1);
    check("pend.hold_data", bus.o_stream_data, 32'hA4A3A2A1);
    drive(0, 8'h00, 0, 1);
    step();
    check("pend.second_val",  32'(bus.o_stream_val), 1);
    check("pend.second_data", bus.o_stream_data, 32'h000000C3);
    check("pend.second_len",  32'(bus.o_stream_len), 1);
    step();
    check("pend.drained", 32'(bus.o_stream_val), 0);

    // asynchronous reset with a held word and a 3-byte partial
    for (int i = 0; i < 7; i++) begin
      drive(1, 8'hE0 + 8'(i), 0, 0);
      step();
    end
    drive(0, 8'h00, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("arst.val",  32'(bus.o_stream_val), 0);
    check("arst.busy", 32'(bus.busy), 0);
    check("arst.rdy",  32'(bus.i_stream_rdy), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    step();
    check("arst.rdy_back", 32'(bus.i_stream_rdy), 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hD1 + 8'(i), 0, 1);
      step();
    end
    drive(0, 8'h00, 0, 1);
    check("arst.fresh_val",  32'(bus.o_stream_val), 1);
    check("arst.fresh_data", bus.o_stream_data, 32'hD4D3D2D1);
    check("arst.fresh_len",  32'(bus.o_stream_len), 4);
    step();

    // randomized traffic: dense input, then sparse input to exercise the timeout
    for (int n = 0; n < 800; n++) begin
      int val_pct = (n < 400) ? 70 : 8;
      drive(($urandom_range(99) < val_pct), 8'($urandom), ($urandom_range(99) < 4),
            ($urandom_range(99) < 60));
      step();
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_word_packer.md
Name: gpio_word_packer

Overview:
- Upstream stage for crossbar input port 1. Accepts a narrow byte stream from the GPIO pins over val/rdy and packs it into 32-bit words, which it presents to the crossbar's 32-bit recv_msg/recv_val/recv_rdy lane.
- Holds two registers: an assembly register and an output register. A new word can fill while the previous one waits for the crossbar.
- An idle timeout and an explicit flush emit partial words, zero-padded.

Parameters:
- BYTE_W, 8: width of one input beat.
- N_BYTES, 4: beats per output word; output width = BYTE_W*N_BYTES = 32.
- TIMEOUT, 16: idle cycles before a partial word is flushed automatically; 0 disables the auto-flush.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- i_stream_val  in  1  input byte valid.
- i_stream_data  in  BYTE_W  input byte.
- i_stream_rdy  out  1  packer can accept a byte.
- flush  in  1  single-cycle pulse: emit the partial word now.
- o_stream_val  out  1  output word valid.
- o_stream_data  out  32  packed word.
- o_stream_len  out  3  number of valid bytes in o_stream_data (1..4).
- o_stream_rdy  in  1  downstream (crossbar) ready.
- busy  out  1  assembly register or output register holds data.

Behaviour:
- Reset, asynchronous while reset=0:
  - asm_cnt=0, asm_data=0, idle_cnt=0.
  - out_full=0, o_stream_val=0, o_stream_data=0, o_stream_len=0.
  - busy=0.
  - i_stream_rdy=0 while reset is asserted, then 1 from the first cycle after release.
- Reset mid-operation discards both the partial word and the held word. No output is produced for them.
- Input fire = i_stream_val & i_stream_rdy.
  - The byte is written to asm_data[asm_cnt*8 +: 8], so the first byte lands in bits [7:0] (little-endian). asm_cnt increments.
- Output fire = o_stream_val & o_stream_rdy. It clears out_full at the clock edge.
  - o_stream_val = out_full (registered).
  - o_stream_data and o_stream_len are stable while o_stream_val=1 and o_stream_rdy=0.
- Transfer (asm -> out) happens when both hold:
  - asm_cnt reaches N_BYTES (counting the fire this cycle), or a flush condition holds with asm_cnt>0;
  - AND the output register is free, i.e. !out_full or output fire this cycle.
- On transfer:
  - out_data is loaded with asm_data; unfilled bytes are 0.
  - out_len is loaded with the byte count.
  - asm_cnt and asm_data are cleared.
  - Transfer latency: the word is visible on o_stream_val one cycle after the 4th byte fires.
- Flush condition: flush=1, OR (TIMEOUT!=0 and idle_cnt==TIMEOUT-1 and no input fire this cycle).
- idle_cnt:
  - clears on any input fire, on transfer, and whenever asm_cnt==0;
  - otherwise increments, saturating at TIMEOUT-1.
- Pending flush: if a flush condition occurs while out_full=1 and there is no output fire, the flush is remembered in flush_pend. The transfer occurs on the first cycle the output register frees. flush_pend clears on transfer.
- i_stream_rdy = !(asm_cnt==N_BYTES-1 completed, i.e. assembly full, & out_full & !o_stream_rdy). Registered form:
  - rdy drops only when asm holds 4 bytes that could not transfer;
  - the implementation holds completed bytes in asm with asm_cnt=N_BYTES; i_stream_rdy=0 while asm_cnt==N_BYTES.
- Simultaneous events:
  - Input fire on the 4th byte plus output fire in the same cycle: the transfer happens, with no bubble.
  - Flush and 4th-byte fire in the same cycle: the full word is emitted with len=4, as one word.
  - flush with asm_cnt==0: no-op; it is not latched.
- Throughput: one word per 4 cycles sustained when o_stream_rdy=1 constantly.
- busy = (asm_cnt!=0) | out_full.

Test Plan:
- Basic pack: release reset; send 0x11,0x22,0x33,0x44 on back-to-back cycles with o_stream_rdy=1 -> o_stream_val=1 on the cycle after 0x44, o_stream_data=0x44332211, o_stream_len=4; i_stream_rdy stays 1 throughout.
- Backpressure: o_stream_rdy=0; send 8 bytes 0x01..0x08 -> first word 0x04030201 held stable. Bytes 5..8 are accepted, then i_stream_rdy=0. Raise o_stream_rdy -> 0x04030201 is emitted, then 0x08070605 on the next cycle. i_stream_rdy returns to 1.
- Explicit flush: send 0xAA,0xBB, pulse flush -> next cycle o_stream_data=0x0000BBAA, o_stream_len=2. A flush with an empty packer produces no output.
- Timeout: TIMEOUT=16; send 0x5A and go idle -> exactly 16 cycles after the byte fires, o_stream_val=1, data=0x0000005A, len=1. With TIMEOUT=0, no output appears after 100 idle cycles.
- Pending flush: hold word A with o_stream_rdy=0; send 0xC3 and pulse flush -> no second word yet. Raise o_stream_rdy -> A is emitted, then 0x000000C3 with len=1 on the following cycle.
- Reset mid-operation: 3 bytes in asm and a word held in out; drive reset=0 asynchronously, between clock edges -> o_stream_val=0 and busy=0 immediately. After release, a fresh 4-byte sequence packs correctly with no residue from before.
